moore_drv: RTL and testbench

MOORE_DRV -- requirements
Module: moore_drv

---
 rtl/moore_drv_pkg.sv | 62 ++++++
 rtl/moore_drv_model.sv | 29 ++
 rtl/moore_drv.sv | 130 +++++++++++++
 tb/tb_moore_drv.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_drv_pkg.sv
// Shared definitions for the Moore-machine driver: downstream state
// encodings, control FSM encodings, the per-state output table and the
// helpers that steer the downstream machine toward a target output bit.
package moore_drv_pkg;

  // Downstream Moore machine states
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } mstate_t;

  // Driver control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } ctl_t;

  // Output of each downstream state, indexed by state encoding:
  // S0 -> 0, S1 -> 1, S2 -> 0, S3 -> 1
  localparam logic [3:0] QOUT_TBL = 4'b1010;

  // Moore output of a downstream state
  function automatic logic qout_of(input mstate_t s);
    return QOUT_TBL[s];
  endfunction

  // Downstream transition function
  function automatic mstate_t next_state(input mstate_t s, input logic d);
    mstate_t n;
    case (s)
      S0:      n = d ? S1 : S0;
      S1:      n = d ? S2 : S3;
      S2:      n = d ? S0 : S2;
      default: n = d ? S2 : S3;
    endcase
    return n;
  endfunction

  // From S2 the only one-step successors (S0, S2) both output 0, so a
  // target of 1 cannot be produced in the next cycle.
  function automatic logic unreachable(input mstate_t s, input logic t);
    return (s == S2) && t;
  endfunction

  // Drive bit that makes the downstream output equal t one cycle later.
  // From S2 with t=0, din=1 is preferred because it lands in S0, from
  // which both output values stay reachable.
  function automatic logic drive_bit(input mstate_t s, input logic t);
    logic d;
    case (s)
      S0:      d = t;
      S2:      d = 1'b1;
      default: d = ~t;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/moore_drv_model.sv
// Shadow copy of the downstream Moore machine. It advances only when the
// driver presents a meaningful bit, so it stays in lock-step with the real
// machine which is clocked by the same din/dvalid.
module moore_model
  import moore_drv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    din,
  output mstate_t state,
  output logic    qout
);

  // Shadow state register, steps only on valid drive bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else if (en) begin
      state <= next_state(state, din);
    end
  end

  // Moore output decoded from the current state
  always_comb begin
    qout = qout_of(state);
  end

endmodule

// File: rtl/moore_drv.sv
// Serial driver that steers a downstream Moore machine so that its output
// reproduces a requested bit pattern, MSB first. A shadow model tracks the
// downstream state so each drive bit can be chosen one cycle ahead; target
// bits that the machine cannot produce from its current state abort the
// sequence with an err pulse.
module moore_drv
  import moore_drv_pkg::*;
#(
  parameter int PW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [LW-1:0] len,
  output logic          ready,
  output logic          din,
  output logic          dvalid,
  output logic          done,
  output logic          err,
  output logic [1:0]    mstate
);

  // Longest usable length expressed one bit wider than len so that the
  // clamp comparison cannot overflow.
  localparam logic [LW:0] PW_LEN = (LW+1)'(PW);

  ctl_t          st;
  ctl_t          st_nx;
  logic [LW-1:0] idx;
  logic [PW-1:0] pat_p0;
  logic [LW-1:0] len_p0;
  logic [LW-1:0] len_clamped;
  logic          accept;
  logic          step;
  logic          tbit;
  mstate_t       shadow;
  logic          unused_qout;

  // Lengths beyond the pattern width use the whole pattern
  always_comb begin
    len_clamped = len;
    if ({1'b0, len} > PW_LEN) begin
      len_clamped = PW_LEN[LW-1:0];
    end
  end

  assign accept = (st == IDLE) && start;
  assign tbit   = pat_p0[PW-1];

  // Next-state and Moore outputs of the control FSM
  always_comb begin
    st_nx  = st;
    ready  = 1'b0;
    din    = 1'b0;
    dvalid = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    step   = 1'b0;
    case (st)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          st_nx = (len == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (unreachable(shadow, tbit)) begin
          // Hold the shadow state and drop the rest of the pattern
          st_nx = ERR;
        end else begin
          dvalid = 1'b1;
          din    = drive_bit(shadow, tbit);
          step   = 1'b1;
          if (idx == len_p0 - LW'(1)) begin
            st_nx = DONE;
          end
        end
      end
      DONE: begin
        done  = 1'b1;
        st_nx = IDLE;
      end
      default: begin
        err   = 1'b1;
        st_nx = IDLE;
      end
    endcase
  end

  // Control state and bit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      idx <= '0;
    end else begin
      st <= st_nx;
      if (accept) begin
        idx <= '0;
      end else if (step) begin
        idx <= idx + LW'(1);
      end
    end
  end

  // ---- stage p0: latched pattern shift register and length ----
  // Pattern shifts left so the current target bit is always the MSB
  always_ff @(posedge clk) begin
    if (accept) begin
      pat_p0 <= pattern;
      len_p0 <= len_clamped;
    end else if (step) begin
      pat_p0 <= pat_p0 << 1;
    end
  end

  // Shadow of the downstream machine; its state persists across sequences
  moore_model u_shadow (
    .clk   (clk),
    .rst   (rst),
    .en    (step),
    .din   (din),
    .state (shadow),
    .qout  (unused_qout)
  );

  assign mstate = shadow;

endmodule

// File: tb/tb_moore_drv.sv
// Bench for moore_drv: drives sequences into the driver, runs an independent
// copy of the downstream Moore machine from din/dvalid, and compares drive
// bits and downstream outputs against expectations queued at stimulus time.
module tb_moore_drv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       ready;
  logic       din;
  logic       dvalid;
  logic       done;
  logic       err;
  logic [1:0] mstate;

  int tests = 0;
  int fails = 0;
  int done_cyc;

  logic q_din[$];
  logic q_tgt[$];

  logic [1:0] ds_st;
  logic       ds_qout;

  always #5 clk = ~clk;

  moore_drv #(.PW(8), .LW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .ready   (ready),
    .din     (din),
    .dvalid  (dvalid),
    .done    (done),
    .err     (err),
    .mstate  (mstate)
  );

  // Downstream Moore machine, reset by the same rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_st <= 2'd0;
    end else if (dvalid) begin
      case (ds_st)
        2'd0:    ds_st <= din ? 2'd1 : 2'd0;
        2'd1:    ds_st <= din ? 2'd2 : 2'd3;
        2'd2:    ds_st <= din ? 2'd0 : 2'd2;
        default: ds_st <= din ? 2'd2 : 2'd3;
      endcase
    end
  end

  always_comb begin
    case (ds_st)
      2'd1, 2'd3: ds_qout = 1'b1;
      default:    ds_qout = 1'b0;
    endcase
  end

  // Queue expected drive/target bits for a pattern starting from the
  // current downstream state; reports expected err, bit count, final state.
  task automatic plan(input logic [7:0] pat, input logic [3:0] ln,
                      output logic e, output int n, output logic [1:0] fin);
    logic [1:0] s;
    logic t;
    logic d;
    int lim;
    s = ds_st;
    lim = (ln > 4'd8) ? 8 : int'(ln);
    e = 1'b0;
    n = 0;
    for (int k = 0; k < lim; k++) begin
      t = pat[7-k];
      if (s == 2'd2 && t) begin
        e = 1'b1;
        break;
      end
      case (s)
        2'd0:    d = t;
        2'd2:    d = 1'b1;
        default: d = ~t;
      endcase
      q_din.push_back(d);
      q_tgt.push_back(t);
      n++;
      case (s)
        2'd0:    s = d ? 2'd1 : 2'd0;
        2'd1:    s = d ? 2'd2 : 2'd3;
        2'd2:    s = d ? 2'd0 : 2'd2;
        default: s = d ? 2'd2 : 2'd3;
      endcase
    end
    fin = s;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge clk);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready-wait: got %b want 1", name, ready);
    end
  endtask

  // Issue one sequence and check every cycle until done or err
  task automatic run_seq(input string name, input logic [7:0] pat, input logic [3:0] ln,
                         input logic exp_err, input int exp_bits,
                         input logic [1:0] exp_fin, input logic hold);
    int nbits;
    int c;
    logic pend;
    logic pend_t;
    logic exp_d;
    logic fin;
    logic got_done;
    logic got_err;
    wait_ready(name);
    pattern = pat;
    len = ln;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    pattern = ~pat;
    len = ~ln;
    nbits = 0;
    pend = 1'b0;
    pend_t = 1'b0;
    fin = 1'b0;
    got_done = 1'b0;
    got_err = 1'b0;
    done_cyc = -1;
    for (c = 0; c < 40 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (pend) begin
        tests++;
        if (ds_qout !== pend_t) begin
          fails++;
          $display("FAIL %s qout bit %0d: got %b want %b", name, nbits-1, ds_qout, pend_t);
        end
        pend = 1'b0;
      end
      if (dvalid !== 1'b1) begin
        tests++;
        if (din !== 1'b0) begin
          fails++;
          $display("FAIL %s din-idle cycle %0d: got %b want 0", name, c, din);
        end
      end else begin
        tests++;
        if (q_din.size() == 0) begin
          fails++;
          $display("FAIL %s extra bit %0d: got dvalid 1 want 0", name, nbits);
        end else begin
          exp_d = q_din.pop_front();
          pend_t = q_tgt.pop_front();
          pend = 1'b1;
          if (din !== exp_d) begin
            fails++;
            $display("FAIL %s din bit %0d: got %b want %b", name, nbits, din, exp_d);
          end
        end
        nbits++;
      end
      if (done === 1'b1 || err === 1'b1) begin
        got_done = done;
        got_err = err;
        fin = 1'b1;
        done_cyc = c + 2;
        if (hold) start = 1'b0;
      end
    end
    start = 1'b0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL %s timeout: got no done/err want a pulse within 40 cycles", name);
    end
    tests++;
    if (got_err !== exp_err || got_done !== !exp_err) begin
      fails++;
      $display("FAIL %s outcome: got done=%b err=%b want err=%b", name, got_done, got_err, exp_err);
    end
    tests++;
    if (nbits != exp_bits || q_din.size() != 0) begin
      fails++;
      $display("FAIL %s bit count: got %0d want %0d", name, nbits, exp_bits);
    end
    tests++;
    if (mstate !== exp_fin || ds_st !== exp_fin) begin
      fails++;
      $display("FAIL %s final state: got mstate=%0d ds=%0d want %0d", name, mstate, ds_st, exp_fin);
    end
    @(negedge clk);
    tests++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s after pulse: got ready=%b done=%b err=%b want 1 0 0", name, ready, done, err);
    end
    q_din.delete();
    q_tgt.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL %s ready: got %b want 1", name, ready); end
    tests++;
    if (din !== 1'b0) begin fails++; $display("FAIL %s din: got %b want 0", name, din); end
    tests++;
    if (dvalid !== 1'b0) begin fails++; $display("FAIL %s dvalid: got %b want 0", name, dvalid); end
    tests++;
    if (done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s pulses: got done=%b err=%b want 0 0", name, done, err);
    end
    tests++;
    if (mstate !== 2'd0) begin fails++; $display("FAIL %s mstate: got %0d want 0", name, mstate); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] p;
    p = {4'b1100, 4'($urandom)};
    q_din = '{1'b1, 1'b0, 1'b1, 1'b1};
    q_tgt = '{1'b1, 1'b1, 1'b0, 1'b0};
    run_seq("basic", p, 4'd4, 1'b0, 4, 2'd0, 1'b0);
  endtask

  task automatic test_unreachable();
    logic [7:0] p;
    p = {3'b101, 5'($urandom)};
    q_din = '{1'b1, 1'b1};
    q_tgt = '{1'b1, 1'b0};
    run_seq("unreach", p, 4'd3, 1'b1, 2, 2'd2, 1'b0);
  endtask

  task automatic test_len_zero();
    run_seq("len0", 8'($urandom), 4'd0, 1'b0, 0, 2'd2, 1'b0);
    tests++;
    if (done_cyc != 2) begin
      fails++;
      $display("FAIL len0 latency: got done in cycle %0d want 2", done_cyc);
    end
  endtask

  task automatic test_clamp();
    logic e;
    int n;
    logic [1:0] f;
    logic [7:0] p;
    p = 8'b0110_0110;
    plan(p, 4'd13, e, n, f);
    run_seq("clamp", p, 4'd13, e, n, f, 1'b0);
  endtask

  task automatic test_start_held();
    logic e;
    int n;
    logic [1:0] f;
    logic [7:0] p;
    p = 8'b0100_1101;
    plan(p, 4'd8, e, n, f);
    run_seq("held", p, 4'd8, e, n, f, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic e;
    int n;
    logic [1:0] f;
    logic [7:0] p;
    logic [3:0] l;
    for (int i = 0; i < 8; i++) begin
      p = 8'($urandom);
      l = 4'($urandom_range(1, 8));
      plan(p, l, e, n, f);
      run_seq("b2b", p, l, e, n, f, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pattern = 8'b1100_1100;
    len = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dvalid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid bit3 dvalid: got %b want 1", dvalid);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || err !== 1'b0 || dvalid !== 1'b0 || ready !== 1'b1) begin
        fails++;
        $display("FAIL rstmid aftermath %0d: got done=%b err=%b dvalid=%b ready=%b want 0 0 0 1",
                 i, done, err, dvalid, ready);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_unreachable();
    test_len_zero();
    test_clamp();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
